bridge_mem_arbiter: RTL and testbench

BRIDGE_MEM_ARBITER -- requirements
Module: bridge_mem_arbiter

---
 rtl/bridge_mem_arbiter_pkg.sv | 36 +++
 rtl/bridge_mem_arbiter_if.sv | 30 +++
 rtl/rr_arbiter.sv | 27 ++
 rtl/bridge_mem_arbiter.sv | 110 +++++++++++
 tb/tb_bridge_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_mem_arbiter_pkg.sv
// Shared definitions for the three-requester burst memory arbiter:
// the FSM encoding, requester count, burst length width and index helpers.
package bridge_mem_arbiter_pkg;

    localparam int NUM_REQ   = 3;
    localparam int LEN_WIDTH = 2;
    localparam int IDX_WIDTH = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef logic [IDX_WIDTH-1:0] req_idx_t;
    typedef logic [NUM_REQ-1:0]   req_vec_t;

    // Requester index (base + offset) wrapped modulo NUM_REQ.
    function automatic req_idx_t rr_index(req_idx_t base, req_idx_t offset);
        logic [IDX_WIDTH:0] sum;
        sum = {1'b0, base} + {1'b0, offset};
        if (sum >= (IDX_WIDTH+1)'(NUM_REQ)) begin
            sum = sum - (IDX_WIDTH+1)'(NUM_REQ);
        end
        return sum[IDX_WIDTH-1:0];
    endfunction

    function automatic req_idx_t onehot_to_idx(req_vec_t vec);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec[i]) begin
                idx = req_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bridge_mem_arbiter_if.sv
// Requester-side bus of the arbiter: packed per-requester request fields
// going in, grant/ack/read-data handshake coming back.
interface bridge_mem_arbiter_if
    import bridge_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  len;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [NUM_REQ-1:0]            rvalid;

    modport master (
        output req, we, addr, len, wdata,
        input  gnt, ack, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, len, wdata,
        output gnt, ack, rdata, rvalid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at ptr and
// returns the first one found as a one-hot grant.
module rr_arbiter
    import bridge_mem_arbiter_pkg::*;
(
    input  req_vec_t req,
    input  req_idx_t ptr,
    output req_vec_t grant
);

    req_idx_t idx;
    logic     found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_index(ptr, req_idx_t'(i));
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bridge_mem_arbiter.sv
// Three-requester burst arbiter in front of a small single-port register
// memory; one burst at a time, one word per cycle, round-robin fairness.
module bridge_mem_arbiter
    import bridge_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
)(
    input  logic                  CLK_100M,
    input  logic                  reset,
    bridge_mem_arbiter_if.slave   bus
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
    logic [LEN_WIDTH-1:0]  req_len   [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_wdata [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_addr[g]  = bus.addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_len[g]   = bus.len[g*LEN_WIDTH +: LEN_WIDTH];
        assign req_wdata[g] = bus.wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [0:0]            state;
    req_vec_t              gnt_q;
    req_idx_t              win_idx;
    req_idx_t              rr_ptr;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    req_vec_t              rvalid_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    req_vec_t grant;
    req_idx_t grant_idx;
    logic     win_req;
    logic     beat_active;
    logic     last_beat;

    rr_arbiter u_rr_arbiter (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign grant_idx   = onehot_to_idx(grant);
    assign win_req     = bus.req[win_idx];
    // A beat only happens while the winner still holds its request.
    assign beat_active = (state == ST_BURST) && win_req;
    assign last_beat   = (beat == len_q);

    assign bus.gnt    = gnt_q;
    assign bus.ack    = beat_active ? gnt_q : '0;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;

    always_ff @(posedge CLK_100M or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            gnt_q    <= '0;
            win_idx  <= '0;
            rr_ptr   <= '0;
            cur_addr <= '0;
            len_q    <= '0;
            beat     <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rvalid_q <= '0;
            if (state == ST_IDLE) begin
                if (|bus.req) begin
                    state    <= ST_BURST;
                    gnt_q    <= grant;
                    win_idx  <= grant_idx;
                    cur_addr <= req_addr[grant_idx];
                    len_q    <= req_len[grant_idx];
                    we_q     <= bus.we[grant_idx];
                    beat     <= '0;
                end
            end else begin
                if (beat_active) begin
                    if (we_q) begin
                        mem[cur_addr] <= req_wdata[win_idx];
                    end else begin
                        rdata_q  <= mem[cur_addr];
                        rvalid_q <= gnt_q;
                    end
                    cur_addr <= cur_addr + 1'b1;
                    beat     <= beat + 1'b1;
                end
                // Normal completion and an abandoned burst both hand priority on.
                if (!beat_active || last_beat) begin
                    state  <= ST_IDLE;
                    gnt_q  <= '0;
                    beat   <= '0;
                    rr_ptr <= rr_index(win_idx, req_idx_t'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_bridge_mem_arbiter.sv
// Directed bench for bridge_mem_arbiter: writes, read-back, wrap, fairness,
// abort and mid-burst reset, each with hand-computed expectations.
module tb_bridge_mem_arbiter;
    import bridge_mem_arbiter_pkg::*;

    localparam int AW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset_n;
    int   vecs = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bridge_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bridge_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK_100M (clk),
        .reset    (reset_n),
        .bus      (bus.slave)
    );

    task automatic set_req(input int i, input logic on, input logic wr,
                           input logic [AW-1:0] a, input logic [1:0] l, input logic [DW-1:0] d);
        bus.req[i]              = on;
        bus.we[i]               = wr;
        bus.addr[i*AW +: AW]    = a;
        bus.len[i*2 +: 2]       = l;
        bus.wdata[i*DW +: DW]   = d;
    endtask

    task automatic set_wdata(input int i, input logic [DW-1:0] d);
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.len = '0; bus.wdata = '0;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        @(negedge clk);
        vecs++;
        if (bus.gnt !== 3'b000 || bus.ack !== 3'b000 || bus.rvalid !== 3'b000 || bus.rdata !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got gnt=%b ack=%b rvalid=%b rdata=%h expected all zero",
                     bus.gnt, bus.ack, bus.rvalid, bus.rdata);
        end
        bad = -1;
        for (int i = 0; i < 16; i++) if (dut.mem[i] !== 16'h0000 && bad < 0) bad = i;
        vecs++;
        if (bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mem: got mem[%0d]=%h expected 0000", bad, dut.mem[bad]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 1'b1, 4'd2, 2'd3, 16'h00A1);
        tick();
        for (int b = 0; b < 4; b++) begin
            set_wdata(0, 16'h00A1 + 16'(b));
            @(negedge clk);
            vecs++;
            if (bus.gnt !== 3'b001 || bus.ack !== 3'b001) begin
                miscompares++;
                $display("[TB] FAIL write_beat%0d: got gnt=%b ack=%b expected gnt=001 ack=001", b, bus.gnt, bus.ack);
            end
            tick();
        end
        set_req(0, 1'b0, 1'b0, 4'd0, 2'd0, 16'h0000);
        @(negedge clk);
        vecs++;
        if (bus.gnt !== 3'b000 || bus.ack !== 3'b000 || dut.state !== ST_IDLE) begin
            miscompares++;
            $display("[TB] FAIL write_idle: got gnt=%b ack=%b state=%b expected 000 000 %b",
                     bus.gnt, bus.ack, dut.state, ST_IDLE);
        end
        for (int i = 0; i < 4; i++) begin
            vecs++;
            if (dut.mem[2+i] !== 16'h00A1 + 16'(i)) begin
                miscompares++;
                $display("[TB] FAIL write_mem%0d: got %h expected %h", 2+i, dut.mem[2+i], 16'h00A1 + 16'(i));
            end
        end
        tick();
    endtask

    task automatic test_read_back();
        set_req(1, 1'b1, 1'b0, 4'd2, 2'd3, 16'h0000);
        tick();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            vecs++;
            if (bus.ack !== 3'b010) begin
                miscompares++;
                $display("[TB] FAIL read_ack%0d: got %b expected 010", b, bus.ack);
            end
            vecs++;
            if (b == 0) begin
                if (bus.rvalid !== 3'b000) begin
                    miscompares++;
                    $display("[TB] FAIL read_first_latency: got rvalid=%b expected 000", bus.rvalid);
                end
            end else if (bus.rvalid !== 3'b010 || bus.rdata !== 16'h00A0 + 16'(b)) begin
                miscompares++;
                $display("[TB] FAIL read_data%0d: got rvalid=%b rdata=%h expected 010 %h",
                         b-1, bus.rvalid, bus.rdata, 16'h00A0 + 16'(b));
            end
            tick();
        end
        set_req(1, 1'b0, 1'b0, 4'd0, 2'd0, 16'h0000);
        @(negedge clk);
        vecs++;
        if (bus.rvalid !== 3'b010 || bus.rdata !== 16'h00A4 || bus.gnt !== 3'b000 || bus.ack !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL read_last: got rvalid=%b rdata=%h gnt=%b ack=%b expected 010 00a4 000 000",
                     bus.rvalid, bus.rdata, bus.gnt, bus.ack);
        end
        tick();
        @(negedge clk);
        vecs++;
        if (bus.rvalid !== 3'b000 || bus.rdata !== 16'h00A4) begin
            miscompares++;
            $display("[TB] FAIL read_hold: got rvalid=%b rdata=%h expected 000 00a4", bus.rvalid, bus.rdata);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [3:0] exp_addr [4];
        exp_addr[0] = 4'd14; exp_addr[1] = 4'd15; exp_addr[2] = 4'd0; exp_addr[3] = 4'd1;
        set_req(2, 1'b1, 1'b1, 4'd14, 2'd3, 16'h0001);
        tick();
        for (int b = 0; b < 4; b++) begin
            set_wdata(2, 16'(b + 1));
            @(negedge clk);
            vecs++;
            if (bus.ack !== 3'b100) begin
                miscompares++;
                $display("[TB] FAIL wrap_ack%0d: got %b expected 100", b, bus.ack);
            end
            tick();
        end
        set_req(2, 1'b0, 1'b0, 4'd0, 2'd0, 16'h0000);
        for (int b = 0; b < 4; b++) begin
            vecs++;
            if (dut.mem[exp_addr[b]] !== 16'(b + 1)) begin
                miscompares++;
                $display("[TB] FAIL wrap_mem%0d: got %h expected %h", exp_addr[b], dut.mem[exp_addr[b]], 16'(b + 1));
            end
        end
        vecs++;
        if (dut.mem[2] !== 16'h00A1) begin
            miscompares++;
            $display("[TB] FAIL wrap_untouched: got mem[2]=%h expected 00a1", dut.mem[2]);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [2:0] exp;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 4'd0, 2'd0, 16'h0000);
        tick();
        for (int k = 0; k < 6; k++) begin
            exp = 3'(1 << (k % 3));
            @(negedge clk);
            vecs++;
            if (bus.gnt !== exp || bus.ack !== exp) begin
                miscompares++;
                $display("[TB] FAIL fair_grant%0d: got gnt=%b ack=%b expected %b", k, bus.gnt, bus.ack, exp);
            end
            tick();
            if (k == 5) bus.req = 3'b000;
            @(negedge clk);
            vecs++;
            if (bus.gnt !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL fair_idle_gap%0d: got gnt=%b expected 000", k, bus.gnt);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        set_req(2, 1'b1, 1'b1, 4'd8, 2'd3, 16'h0055);
        tick();
        @(negedge clk);
        vecs++;
        if (bus.gnt !== 3'b100 || bus.ack !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL abort_beat0: got gnt=%b ack=%b expected 100 100", bus.gnt, bus.ack);
        end
        tick();
        set_wdata(2, 16'h0066);
        set_req(0, 1'b1, 1'b1, 4'd12, 2'd0, 16'h0077);
        @(negedge clk);
        vecs++;
        if (bus.gnt !== 3'b100 || bus.ack !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL abort_beat1: got gnt=%b ack=%b expected 100 100", bus.gnt, bus.ack);
        end
        tick();
        bus.req[2] = 1'b0;
        @(negedge clk);
        vecs++;
        if (bus.ack !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL abort_no_beat: got ack=%b expected 000", bus.ack);
        end
        tick();
        @(negedge clk);
        vecs++;
        if (bus.gnt !== 3'b000 || dut.state !== ST_IDLE) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: got gnt=%b state=%b expected 000 %b", bus.gnt, dut.state, ST_IDLE);
        end
        tick();
        @(negedge clk);
        vecs++;
        if (bus.gnt !== 3'b001 || bus.ack !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL abort_pending_grant: got gnt=%b ack=%b expected 001 001", bus.gnt, bus.ack);
        end
        tick();
        set_req(0, 1'b0, 1'b0, 4'd0, 2'd0, 16'h0000);
        set_req(2, 1'b0, 1'b0, 4'd0, 2'd0, 16'h0000);
        vecs++;
        if (dut.mem[8] !== 16'h0055 || dut.mem[9] !== 16'h0066 || dut.mem[10] !== 16'h0000 ||
            dut.mem[11] !== 16'h0000 || dut.mem[12] !== 16'h0077) begin
            miscompares++;
            $display("[TB] FAIL abort_mem: got %h %h %h %h %h expected 0055 0066 0000 0000 0077",
                     dut.mem[8], dut.mem[9], dut.mem[10], dut.mem[11], dut.mem[12]);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int bad;
        set_req(1, 1'b1, 1'b1, 4'd4, 2'd3, 16'h0099);
        tick();
        @(negedge clk);
        vecs++;
        if (bus.ack !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL rst_burst_start: got ack=%b expected 010", bus.ack);
        end
        tick();
        set_wdata(1, 16'h009A);
        #2 reset_n = 1'b0;
        #1;
        vecs++;
        if (bus.gnt !== 3'b000 || bus.ack !== 3'b000 || bus.rvalid !== 3'b000 || bus.rdata !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_outputs: got gnt=%b ack=%b rvalid=%b rdata=%h expected all zero",
                     bus.gnt, bus.ack, bus.rvalid, bus.rdata);
        end
        bad = -1;
        for (int i = 0; i < 16; i++) if (dut.mem[i] !== 16'h0000 && bad < 0) bad = i;
        vecs++;
        if (bad >= 0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_mem: got mem[%0d]=%h expected 0000", bad, dut.mem[bad]);
        end
        set_req(1, 1'b0, 1'b0, 4'd0, 2'd0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        vecs++;
        if (dut.state !== ST_IDLE || bus.gnt !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_idle: got state=%b gnt=%b expected %b 000", dut.state, bus.gnt, ST_IDLE);
        end
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 4'd0, 2'd0, 16'h0000);
        tick();
        @(negedge clk);
        vecs++;
        if (bus.gnt !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_ptr: got gnt=%b expected 001", bus.gnt);
        end
        bus.req = 3'b000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_wrap();
        test_fairness();
        test_abort();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
